// File: rtl/tvip_axi_write_arbiter.sv
// Serializes NUM_REQ AXI write requesters onto one AW/W/B manager port with round-robin grants.
// One transaction is in flight at a time. A W-burst length mismatch raises a one-cycle wlast_error.
module tvip_axi_write_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int AW_W = ID_WIDTH + ADDR_WIDTH + 13,
    localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1,
    localparam int B_W  = ID_WIDTH + 2,
    localparam int IW   = $clog2(NUM_REQ)
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [NUM_REQ-1:0]      s_awvalid,
    output logic [NUM_REQ-1:0]      s_awready,
    input  logic [NUM_REQ*AW_W-1:0] s_aw,
    input  logic [NUM_REQ-1:0]      s_wvalid,
    output logic [NUM_REQ-1:0]      s_wready,
    input  logic [NUM_REQ*W_W-1:0]  s_w,
    output logic [NUM_REQ-1:0]      s_bvalid,
    input  logic [NUM_REQ-1:0]      s_bready,
    output logic [NUM_REQ*B_W-1:0]  s_b,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [AW_W-1:0]         m_aw,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [W_W-1:0]          m_w,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [B_W-1:0]          m_b,
    output logic                    grant_valid,
    output logic [IW-1:0]           grant_index,
    output logic                    wlast_error
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   winner;
    logic            any_req;
    logic [7:0]      awlen;
    logic [8:0]      beat;
    logic [8:0]      beat_inc;
    logic            aw_done;
    logic            w_done;
    logic            aw_done_nx;
    logic            w_done_nx;
    logic            w_route;
    logic            w_last;
    logic            burst_end;
    logic            aw_hs;
    logic            w_hs;
    logic            b_hs;
    logic            w_complete;
    logic            len_err;

    logic [AW_W-1:0] aw_slice [NUM_REQ];
    logic [W_W-1:0]  w_slice  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign aw_slice[i]          = s_aw[i*AW_W +: AW_W];
        assign w_slice[i]           = s_w[i*W_W +: W_W];
        assign s_b[i*B_W +: B_W]    = m_b;
    end

    // Payloads pass straight through from the owner; only the handshake signals are gated.
    assign m_aw = aw_slice[grant_index];
    assign m_w  = w_slice[grant_index];

    // Round-robin search starting just after the last owner; lowest offset wins.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch can be inferred.
        logic [IW-1:0] cand;
        cand    = '0;
        winner  = '0;
        any_req = |s_awvalid;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = IW'((int'(rr_ptr) + off) % NUM_REQ);
            if (s_awvalid[cand]) begin
                winner = cand;
            end
        end
    end

    // Handshakes are derived from state and inputs so the output process below has no feedback.
    assign w_route    = ((state == ADDR) || (state == DATA)) && !w_done;
    assign aw_hs      = (state == ADDR) && s_awvalid[grant_index] && m_awready;
    assign w_hs       = w_route && s_wvalid[grant_index] && m_wready;
    assign b_hs       = (state == RESP) && m_bvalid && s_bready[grant_index];
    assign w_last     = w_slice[grant_index][0];
    assign beat_inc   = beat + 9'd1;
    assign burst_end  = (beat_inc == ({1'b0, awlen} + 9'd1));
    assign w_complete = w_hs && (w_last || burst_end);
    assign len_err    = w_hs && (w_last ^ burst_end);
    assign aw_done_nx = aw_done || aw_hs;
    assign w_done_nx  = w_done || w_complete;

    always_comb begin
        state_nx  = state;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;

        if (w_route) begin
            m_wvalid              = s_wvalid[grant_index];
            s_wready[grant_index] = m_wready;
        end

        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = ADDR;
                end
            end
            ADDR: begin
                m_awvalid              = s_awvalid[grant_index];
                s_awready[grant_index] = m_awready;
                if (aw_done_nx) begin
                    state_nx = w_done_nx ? RESP : DATA;
                end
            end
            DATA: begin
                if (w_done_nx) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                m_bready              = s_bready[grant_index];
                s_bvalid[grant_index] = m_bvalid;
                if (b_hs) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nx;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rr_ptr      <= IW'(NUM_REQ - 1);
            grant_valid <= 1'b0;
            grant_index <= '0;
            awlen       <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            beat        <= '0;
            wlast_error <= 1'b0;
        end else begin
            wlast_error <= len_err;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_index <= winner;
                        grant_valid <= 1'b1;
                        awlen       <= aw_slice[winner][12:5];
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        beat        <= '0;
                    end
                end
                ADDR, DATA: begin
                    aw_done <= aw_done_nx;
                    w_done  <= w_done_nx;
                    if (w_hs) begin
                        beat <= beat_inc;
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        rr_ptr      <= grant_index;
                        grant_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tvip_axi_write_arbiter.sv
// Directed and randomized bench for tvip_axi_write_arbiter; expectations come from a per-cycle
// transaction model of the arbiter's rules (owner, AW/W/B phases, beat count, length errors).
module tb_tvip_axi_write_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int ID_WIDTH   = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int AW_W = ID_WIDTH + ADDR_WIDTH + 13;
    localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam int B_W  = ID_WIDTH + 2;
    localparam int IW   = $clog2(NUM_REQ);

    logic                    aclk = 1'b0;
    logic                    areset = 1'b0;
    logic [NUM_REQ-1:0]      s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [NUM_REQ*AW_W-1:0] s_aw;
    logic [NUM_REQ*W_W-1:0]  s_w;
    logic [NUM_REQ*B_W-1:0]  s_b;
    logic                    m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [AW_W-1:0]         m_aw;
    logic [W_W-1:0]          m_w;
    logic [B_W-1:0]          m_b;
    logic                    grant_valid;
    logic [IW-1:0]           grant_index;
    logic                    wlast_error;

    int checks = 0;
    int errors = 0;
    int last_served;
    logic [AW_W-1:0] aw_req  [NUM_REQ];
    int              req_len [NUM_REQ];
    int              req_id  [NUM_REQ];

    tvip_axi_write_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_b(s_b),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w(m_w),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_b(m_b),
        .grant_valid(grant_valid), .grant_index(grant_index), .wlast_error(wlast_error)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [AW_W-1:0] mk_aw(input int id, input logic [31:0] addr, input int len);
        return {ID_WIDTH'(id), ADDR_WIDTH'(addr), 8'(len), 3'd2, 2'b01};
    endfunction

    function automatic logic [W_W-1:0] mk_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        return {data, strb, last};
    endfunction

    function automatic logic [B_W-1:0] mk_b(input int id, input logic [1:0] resp);
        return {ID_WIDTH'(id), resp};
    endfunction

    // The last requester served has lowest priority; search the others in ascending order after it.
    function automatic int predict();
        for (int off = 1; off <= NUM_REQ; off++) begin
            int c;
            c = (last_served + off) % NUM_REQ;
            if (s_awvalid[c]) return c;
        end
        return 0;
    endfunction

    task automatic clear_inputs();
        s_awvalid = '0; s_aw = '0; s_wvalid = '0; s_w = '0; s_bready = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_b = '0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        #1;
        chk("reset_quiet", 64'({grant_valid, grant_index, wlast_error, m_awvalid, m_wvalid, m_bready,
                                s_awready, s_wready, s_bvalid}), 64'(0));
        clear_inputs();
        repeat (2) @(posedge aclk);
        #3 areset = 1'b0;
        last_served = NUM_REQ - 1;
        tick();
    endtask

    task automatic request(input int i, input int id, input int len);
        aw_req[i]  = mk_aw(id, $urandom, len);
        req_len[i] = len;
        req_id[i]  = id;
        s_aw[i*AW_W +: AW_W] = aw_req[i];
        s_awvalid[i] = 1'b1;
    endtask

    // Plays requester r and the slave for one transaction, starting in an IDLE cycle.
    // last_at: beat carrying last (0 = never); nb: beats the requester offers.
    task automatic serve(input int r, input int last_at, input int nb, input int aw_stall,
                         input bit w_early, input int b_stall, input bit rnd_wready,
                         input logic [1:0] resp);
        int len, cyc, offered, accepted, resp_cyc, exp_acc;
        bit aw_seen, wdone, exp_resp, err_pend, err_nx, done, exp_mwv, aw_hs, w_hs, b_hs, last;
        logic [NUM_REQ-1:0] oh;
        logic [W_W-1:0] beats [$];
        len = req_len[r];
        oh  = NUM_REQ'(1) << r;
        #1;
        chk("idle_quiet", 64'({grant_valid, wlast_error, m_awvalid, m_wvalid, m_bready,
                               s_awready, s_wready, s_bvalid}), 64'(0));
        tick();
        for (int k = 1; k <= nb; k++) beats.push_back(mk_w($urandom, 4'($urandom), k == last_at));
        cyc = 0; offered = 0; accepted = 0; resp_cyc = 0;
        aw_seen = 0; wdone = 0; exp_resp = 0; err_pend = 0; done = 0;
        while (cyc < 200 && !done) begin
            m_awready    = !aw_seen && (cyc >= aw_stall);
            s_awvalid[r] = !aw_seen;
            s_wvalid[r]  = (w_early || aw_seen) && (offered < nb);
            s_w[r*W_W +: W_W] = (offered < nb) ? beats[offered] : '0;
            m_wready     = rnd_wready ? ($urandom_range(0, 2) != 0) : 1'b1;
            m_bvalid     = exp_resp;
            s_bready[r]  = exp_resp && (resp_cyc >= b_stall);
            m_b          = mk_b(req_id[r], resp);
            #1;
            exp_mwv = !exp_resp && !wdone && s_wvalid[r];
            chk("grant", 64'({grant_valid, grant_index}), 64'({1'b1, IW'(r)}));
            chk("m_awvalid", 64'(m_awvalid), 64'(!aw_seen));
            if (!aw_seen) chk("m_aw", 64'(m_aw), 64'(aw_req[r]));
            chk("s_awready", 64'(s_awready), 64'((!aw_seen && m_awready) ? oh : '0));
            chk("m_wvalid", 64'(m_wvalid), 64'(exp_mwv));
            if (exp_mwv) chk("m_w", 64'(m_w), 64'(beats[offered]));
            chk("s_wready", 64'(s_wready), 64'((!exp_resp && !wdone && m_wready) ? oh : '0));
            chk("m_bready", 64'(m_bready), 64'(exp_resp && s_bready[r]));
            chk("s_bvalid", 64'(s_bvalid), 64'(exp_resp ? oh : '0));
            chk("s_b", 64'(s_b), 64'({NUM_REQ{mk_b(req_id[r], resp)}}));
            chk("wlast_error", 64'(wlast_error), 64'(err_pend));
            aw_hs  = !aw_seen && m_awready;
            w_hs   = exp_mwv && m_wready;
            b_hs   = exp_resp && s_bready[r];
            err_nx = 0;
            if (w_hs) begin
                accepted++;
                last   = beats[offered][0];
                err_nx = last ? (accepted != len + 1) : (accepted == len + 1);
                if (last || accepted == len + 1) wdone = 1;
                offered++;
            end
            if (aw_hs) aw_seen = 1;
            if (exp_resp) begin
                resp_cyc++;
                if (b_hs) done = 1;
            end else begin
                exp_resp = aw_seen && wdone;
            end
            err_pend = err_nx;
            cyc++;
            tick();
        end
        chk("serve_done", 64'(done), 64'(1));
        exp_acc = (last_at >= 1 && last_at <= len + 1) ? last_at : len + 1;
        chk("w_accepted", 64'(accepted), 64'(exp_acc));
        s_awvalid[r] = 1'b0; s_wvalid[r] = 1'b0; s_bready[r] = 1'b0;
        m_bvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
        last_served = r;
    endtask

    initial begin
        clear_inputs();
        last_served = NUM_REQ - 1;
        #1 areset = 1'b1;
        #2;
        chk("rst_grant", 64'({grant_valid, grant_index, wlast_error}), 64'(0));
        chk("rst_quiet", 64'({m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid}), 64'(0));
        repeat (2) @(posedge aclk);
        #3 areset = 1'b0;
        tick();

        // Single 4-beat burst from requester 1, id 5, OKAY.
        request(1, 5, 3);
        serve(1, 4, 4, 0, 0, 0, 0, 2'b00);

        // Simultaneous requests after reset: 0,1 then 0,1 again.
        do_reset();
        request(0, 1, 1);
        request(1, 2, 2);
        serve(0, 2, 2, 1, 0, 1, 0, 2'b00);
        serve(1, 3, 3, 0, 0, 0, 0, 2'b01);
        request(0, 3, 0);
        request(1, 4, 1);
        serve(0, 1, 1, 0, 0, 0, 0, 2'b00);
        serve(1, 2, 2, 0, 0, 0, 0, 2'b00);

        // W ahead of AW: single-beat burst, AW accepted two cycles in.
        request(0, 3, 0);
        serve(0, 1, 1, 2, 1, 0, 0, 2'b00);

        // Early last on beat 2 of 4.
        request(1, 4, 3);
        serve(1, 2, 2, 0, 0, 0, 0, 2'b10);

        // No last at all on a 2-beat burst; the third offered beat must be blocked.
        request(0, 6, 1);
        serve(0, 0, 3, 1, 1, 0, 0, 2'b00);

        // Reset in the middle of the data phase, after beat 2 of 4.
        request(0, 7, 3);
        #1;
        tick();
        m_awready = 1'b1; m_wready = 1'b1;
        s_wvalid[0] = 1'b1; s_w[0 +: W_W] = mk_w($urandom, 4'hf, 1'b0);
        tick();
        s_awvalid[0] = 1'b0; m_awready = 1'b0;
        s_w[0 +: W_W] = mk_w($urandom, 4'hf, 1'b0);
        tick();
        s_w[0 +: W_W] = mk_w($urandom, 4'hf, 1'b0);
        #1;
        chk("pre_reset_wvalid", 64'({grant_valid, m_wvalid}), 64'(2'b11));
        do_reset();
        request(1, 9, 1);
        serve(1, 2, 2, 0, 0, 0, 0, 2'b00);

        // B backpressure on requester 0 while requester 1 waits.
        request(0, 10, 2);
        request(1, 11, 0);
        serve(0, 3, 3, 0, 0, 5, 0, 2'b00);
        serve(1, 1, 1, 0, 0, 0, 0, 2'b00);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            int r, len, last_at, nb;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!s_awvalid[i] && $urandom_range(0, 1) == 1) request(i, $urandom_range(0, 15), $urandom_range(0, 7));
            end
            if (s_awvalid == '0) request(int'($urandom_range(0, NUM_REQ - 1)), $urandom_range(0, 15), $urandom_range(0, 7));
            r   = predict();
            len = req_len[r];
            case ($urandom_range(0, 4))
                0: begin last_at = 0; nb = len + 2; end
                1: begin last_at = $urandom_range(1, len + 2); nb = last_at; end
                default: begin last_at = len + 1; nb = len + 1; end
            endcase
            serve(r, last_at, nb, $urandom_range(0, 2), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3), 1'b1, 2'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tvip_axi_write_arbiter.md
Name: tvip_axi_write_arbiter

Overview:
Shares one AXI write path (AW/W/B) between NUM_REQ requester ports and serializes them: only one write transaction is in flight at a time. A round-robin grant selects one requester. The grant routes that requester's AW, W and B channels to the single manager-side port. It is released after the B handshake. The block sits between multiple TVIP AXI master agents or DUT initiators and a single AXI slave, and also flags W-burst length violations.

Parameters:
NUM_REQ, 2, number of requester ports (legal 2..8)
ID_WIDTH, 4, AXI ID width
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (multiple of 8)
Derived widths:
- AW_W = ID_WIDTH+ADDR_WIDTH+13, packed {id,addr,len[7:0],size[2:0],burst[1:0]}
- W_W = DATA_WIDTH+DATA_WIDTH/8+1, packed {data,strb,last}
- B_W = ID_WIDTH+2, packed {id,resp}
- IW = $clog2(NUM_REQ)

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  asynchronous, active-high reset
s_awvalid  in  NUM_REQ  per-requester AW valid
s_awready  out  NUM_REQ  per-requester AW ready
s_aw  in  NUM_REQ*AW_W  per-requester AW payload; requester i at slice i
s_wvalid  in  NUM_REQ  per-requester W valid
s_wready  out  NUM_REQ  per-requester W ready
s_w  in  NUM_REQ*W_W  per-requester W payload
s_bvalid  out  NUM_REQ  per-requester B valid
s_bready  in  NUM_REQ  per-requester B ready
s_b  out  NUM_REQ*B_W  B payload, same value broadcast to all slices
m_awvalid / m_awready / m_aw  out/in/out  1/1/AW_W  shared AW channel
m_wvalid / m_wready / m_w  out/in/out  1/1/W_W  shared W channel
m_bvalid / m_bready / m_b  in/out/in  1/1/B_W  shared B channel
grant_valid  out  1  a transaction is owned
grant_index  out  IW  owning requester
wlast_error  out  1  one-cycle pulse on a W-burst length mismatch

Behaviour:
- Reset values: state IDLE, rr_ptr=NUM_REQ-1, grant_valid=0, grant_index=0, wlast_error=0, beat counter 0. All valid and ready outputs are 0.
- States:
  - IDLE: if any s_awvalid, pick the first set bit searching from rr_ptr+1 with modulo wrap. Register grant_index, set grant_valid, latch awlen of the winner, clear aw_done/w_done/beat count, go ADDR. If no s_awvalid, stay.
  - ADDR: m_awvalid=s_awvalid[g], m_aw=s_aw[g], s_awready[g]=m_awready. On handshake set aw_done. W routing is already active in this state, since AXI permits W before or alongside AW.
  - W routing (ADDR and DATA): m_wvalid=s_wvalid[g], m_w=s_w[g], s_wready[g]=m_wready. Each W handshake increments beat. The handshake carrying last sets w_done.
  - DATA: entered when aw_done. Go RESP in the cycle after both aw_done and w_done are set; a same-cycle AW and final-W handshake counts.
  - RESP: m_bready=s_bready[g], s_bvalid[g]=m_bvalid, s_b=m_b. On handshake: rr_ptr=g, grant_valid=0, go IDLE.
- Grant latency: s_awvalid in IDLE → m_awvalid is asserted the next cycle. Minimum back-to-back gap is one IDLE cycle after the B handshake.
- Non-granted requesters see all readies/valids at 0. The m_* valids are 0 outside the states listed above, and m_bready=0 outside RESP.
- Payloads, including ID, pass through unchanged. No ID remapping is needed because transactions are serialized.
- W-burst length check:
  - If last arrives on a beat other than awlen+1, or beat reaches awlen+1 without last, pulse wlast_error the following cycle.
  - In the no-last case, treat the burst as complete (w_done=1) and block further W by holding s_wready[g]=0.
  - Data is still forwarded; no other recovery.
- Fairness: the requester granted last has lowest priority next time. Simultaneous requests never starve, and each waits at most NUM_REQ-1 transactions.
- Reset asserted mid-transaction clears everything immediately (asynchronous). Outstanding handshakes are abandoned and the first grant after reset goes to requester 0.
- Withdrawing s_awvalid after grant is a protocol violation and is not handled.

Test Plan:
- Single request, NUM_REQ=2: requester 1 issues a 4-beat burst, awlen=3, id=5 → m_aw matches s_aw[1], 4 W beats forwarded, B {id=5,resp=OKAY} returned only on s_bvalid[1], wlast_error=0, grant_index=1.
- Simultaneous requests from 0 and 1 after reset → 0 is served first, then 1. Repeating both requests gives the order 0,1,0,1.
- W before AW: requester 0 asserts wvalid with a 1-beat burst two cycles before m_awready → the W handshake completes in ADDR and RESP is entered one cycle after the AW handshake.
- Length error: awlen=3 with wlast on beat 2 → wlast_error pulses exactly one cycle and the transaction still completes through B.
- Reset mid-DATA, after beat 2 of 4 → all valids/readies are 0 in the same cycle. After release, a request from requester 1 is granted with no stale beats.
- Backpressure: hold m_bready low via s_bready[0]=0 for 5 cycles → no new grant is issued, and requester 1's pending AW is stalled until the B handshake.
